// File: rtl/param_mux_ctrl_pkg.sv
// param_mux_pkg: shared types and helpers for the sequenced project mux.
//   state_t : controller FSM states (IDLE / ACTIVE / DRAIN)
//   clog2   : ceiling log2, used to size the break-before-make counter
package param_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/param_mux_ctrl_if.sv
// param_mux_ctrl_if: project-select handshake between the chip controller
// (master) and the mux (slave).
//   sel_valid : request valid            (master -> slave)
//   sel_addr  : requested project index  (master -> slave)
//   sel_ready : request accepted when sel_valid & sel_ready (slave -> master)
//   sel_err   : 1-cycle pulse, accepted index was out of range (slave -> master)
interface param_mux_ctrl_if #(
    parameter int ADDR_W = 5
) ();
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ready;
    logic              sel_err;

    modport master (output sel_valid, sel_addr, input  sel_ready, sel_err);
    modport slave  (input  sel_valid, sel_addr, output sel_ready, sel_err);
endinterface

// File: rtl/param_mux_ctrl_onehot_dec.sv
// onehot_dec: address + enable -> N-bit one-hot vector.
//   addr   : index to decode
//   en     : enable; low gives all zeros
//   onehot : one-hot result; an index >= N decodes to all zeros
module onehot_dec #(
    parameter int N      = 20,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [N-1:0]      onehot
);
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (en && (addr == ADDR_W'(k))) onehot[k] = 1'b1;
        end
    end
endmodule

// File: rtl/param_mux_ctrl.sv
// param_mux_ctrl: sequenced, break-before-make project mux.
//   clk, rst  : clock, synchronous active-high reset
//   ena       : global enable; low drains and turns every project off
//   sel       : select handshake (slave side)
//   active    : a project is currently enabled
//   cur_addr  : index of the enabled (or last enabled) project
//   iw        : shared input bus, gated to the enabled slot only (proj_iw)
//   ow        : registered output of the enabled project
//   proj_ena  : one-hot project enable (registered)
//   proj_iw   : per-slot input bus, slot k at [k*IW_W +: IW_W]
//   proj_ow   : per-slot output bus, slot k at [k*OW_W +: OW_W]
module param_mux_ctrl
    import param_mux_pkg::*;
#(
    parameter int N_PROJ  = 20,
    parameter int ADDR_W  = 5,
    parameter int IW_W    = 18,
    parameter int OW_W    = 24,
    parameter int GAP_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    param_mux_ctrl_if.slave          sel,
    output logic                     active,
    output logic [ADDR_W-1:0]        cur_addr,
    input  logic [IW_W-1:0]          iw,
    output logic [OW_W-1:0]          ow,
    output logic [N_PROJ-1:0]        proj_ena,
    output logic [N_PROJ*IW_W-1:0]   proj_iw,
    input  logic [N_PROJ*OW_W-1:0]   proj_ow
);
    localparam int CNT_W = (clog2(GAP_CYC) < 1) ? 1 : clog2(GAP_CYC);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(GAP_CYC - 1);
    localparam logic [ADDR_W:0]   N_LIM    = (ADDR_W+1)'(N_PROJ);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr_nxt, pending, pending_nxt, dec_addr;
    logic              pend_v, pend_v_nxt, err_q;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_PROJ-1:0] dec_oh;
    logic              accept, in_range, good;

    assign sel.sel_ready = ena & (state != DRAIN);
    assign sel.sel_err   = err_q;
    assign active        = (state == ACTIVE);

    assign accept   = sel.sel_valid & sel.sel_ready;
    assign in_range = ({1'b0, sel.sel_addr} < N_LIM);
    assign good     = accept & in_range;

    // Decoder serves both enable paths: the live request out of IDLE and
    // the held pending index out of DRAIN.
    onehot_dec #(.N(N_PROJ), .ADDR_W(ADDR_W)) u_dec (
        .addr   (dec_addr),
        .en     (ena),
        .onehot (dec_oh)
    );

    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        pending_nxt  = pending;
        pend_v_nxt   = pend_v;
        cnt_nxt      = cnt;
        dec_addr     = sel.sel_addr;
        unique case (state)
            IDLE: begin
                if (good) begin
                    state_nxt    = ACTIVE;
                    cur_addr_nxt = sel.sel_addr;
                end
            end
            ACTIVE: begin
                if (!ena) begin
                    state_nxt  = DRAIN;
                    pend_v_nxt = 1'b0;
                    cnt_nxt    = CNT_INIT;
                end else if (good && (sel.sel_addr != cur_addr)) begin
                    state_nxt   = DRAIN;
                    pending_nxt = sel.sel_addr;
                    pend_v_nxt  = 1'b1;
                    cnt_nxt     = CNT_INIT;
                end
            end
            DRAIN: begin
                dec_addr = pending;
                if (!ena) pend_v_nxt = 1'b0;
                if (cnt == '0) begin
                    // ena low on the last gap cycle also cancels the pending switch
                    if (pend_v && ena) begin
                        state_nxt    = ACTIVE;
                        cur_addr_nxt = pending;
                    end else begin
                        state_nxt = IDLE;
                    end
                    pend_v_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            pending  <= '0;
            pend_v   <= 1'b0;
            cnt      <= '0;
            proj_ena <= '0;
            err_q    <= 1'b0;
            ow       <= '0;
        end else begin
            state    <= state_nxt;
            cur_addr <= cur_addr_nxt;
            pending  <= pending_nxt;
            pend_v   <= pend_v_nxt;
            cnt      <= cnt_nxt;
            err_q    <= accept & ~in_range;
            // Hold the enable while staying ACTIVE; load a fresh one-hot only
            // on entry; everything else is off.
            if (state_nxt == ACTIVE)
                proj_ena <= (state == ACTIVE) ? proj_ena : dec_oh;
            else
                proj_ena <= '0;
            // Only pass data while the slot stays enabled, so ow is already 0
            // in the first DRAIN cycle.
            if ((state == ACTIVE) && (state_nxt == ACTIVE))
                ow <= proj_ow[int'(cur_addr)*OW_W +: OW_W];
            else
                ow <= '0;
        end
    end

    for (genvar k = 0; k < N_PROJ; k++) begin : g_slot
        assign proj_iw[k*IW_W +: IW_W] = proj_ena[k] ? iw : '0;
    end

endmodule

// File: tb/tb_param_mux_ctrl.sv
module tb_param_mux_ctrl;
    localparam int N    = 20;
    localparam int AW   = 5;
    localparam int IW   = 18;
    localparam int OW   = 24;
    localparam int GAP  = 4;

    logic              clk = 1'b0;
    logic              rst, ena;
    logic              active;
    logic [AW-1:0]     cur_addr;
    logic [IW-1:0]     iw;
    logic [OW-1:0]     ow;
    logic [N-1:0]      proj_ena;
    logic [N*IW-1:0]   proj_iw;
    logic [N*OW-1:0]   proj_ow;

    param_mux_ctrl_if #(.ADDR_W(AW)) sel_if ();

    param_mux_ctrl #(.N_PROJ(N), .ADDR_W(AW), .IW_W(IW), .OW_W(OW), .GAP_CYC(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .sel      (sel_if),
        .active   (active),
        .cur_addr (cur_addr),
        .iw       (iw),
        .ow       (ow),
        .proj_ena (proj_ena),
        .proj_iw  (proj_iw),
        .proj_ow  (proj_ow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: which slot is on (-1 = none), remaining gap cycles,
    // slot waiting behind the gap (-1 = none), last enabled slot.
    int           m_slot, m_gap, m_pend, m_last;
    logic         m_err;
    logic [OW-1:0] m_ow;
    logic         iw_fix;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_slot = -1; m_gap = 0; m_pend = -1; m_last = 0; m_err = 1'b0; m_ow = '0;
    endtask

    // One clock: drive inputs, check combinational outputs, advance model,
    // clock, check registered outputs.
    task automatic cyc(input logic r, input logic e, input logic v, input int a);
        logic          rdy, acc;
        int            old;
        logic [N*IW-1:0] eiw;
        logic [N-1:0]  eena;
        rst = r; ena = e; sel_if.sel_valid = v; sel_if.sel_addr = AW'(a);
        if (!iw_fix) iw = IW'($urandom);
        for (int k = 0; k < N; k++) proj_ow[k*OW +: OW] = OW'($urandom);
        #1;
        rdy = e && (m_gap == 0);
        chk("sel_ready", sel_if.sel_ready, rdy);
        eiw = '0;
        if (m_slot >= 0) eiw[m_slot*IW +: IW] = iw;
        chk("proj_iw", proj_iw, eiw);

        if (r) begin
            mreset();
        end else begin
            acc = v && rdy;
            m_err = acc && (a >= N);
            old = m_slot;
            if (m_gap > 0) begin
                if (!e) m_pend = -1;
                m_gap--;
                if (m_gap == 0 && m_pend >= 0) begin
                    m_slot = m_pend; m_last = m_pend; m_pend = -1;
                end
            end else if (m_slot >= 0) begin
                if (!e) begin
                    m_slot = -1; m_gap = GAP; m_pend = -1;
                end else if (acc && a < N && a != m_slot) begin
                    m_slot = -1; m_gap = GAP; m_pend = a;
                end
            end else if (acc && a < N) begin
                m_slot = a; m_last = a;
            end
            m_ow = (old >= 0 && m_slot == old) ? proj_ow[old*OW +: OW] : '0;
        end

        @(posedge clk); #1;
        eena = '0;
        if (m_slot >= 0) eena[m_slot] = 1'b1;
        chk("proj_ena", proj_ena, eena);
        chk("active", active, m_slot >= 0);
        chk("cur_addr", cur_addr, m_last);
        chk("sel_err", sel_if.sel_err, m_err);
        chk("ow", ow, m_ow);
        chk("onehot", $countones(proj_ena) <= 1, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        logic seen9;
        logic [OW-1:0] s3;
        logic [N*IW-1:0] ev;

        iw_fix = 1'b0; iw = '0; proj_ow = '0;
        rst = 1'b1; ena = 1'b0; sel_if.sel_valid = 1'b0; sel_if.sel_addr = '0;
        mreset();
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("rst_ena", proj_ena, 0);
        chk("rst_active", active, 0);
        chk("rst_cur", cur_addr, 0);
        chk("rst_ow", ow, 0);
        chk("rst_err", sel_if.sel_err, 0);

        // 1: select 3 from IDLE
        cyc(1'b0, 1'b1, 1'b1, 3);
        chk("t1_ena", proj_ena, 20'h00008);
        chk("t1_active", active, 1);
        cyc(1'b0, 1'b1, 1'b0, 0);
        s3 = proj_ow[3*OW +: OW];
        chk("t1_ow_slot3", ow, s3);

        // 2: switch 3 -> 7, gap must be exactly GAP cycles
        zeros = 0;
        cyc(1'b0, 1'b1, 1'b1, 7);
        while (proj_ena == '0 && zeros < 10) begin
            zeros++;
            cyc(1'b0, 1'b1, 1'b0, 0);
        end
        chk("t2_gap_len", zeros, GAP);
        chk("t2_ena7", proj_ena, 20'h00080);
        chk("t2_cur7", cur_addr, 7);

        // 3: out-of-range select
        cyc(1'b0, 1'b1, 1'b1, 25);
        chk("t3_err", sel_if.sel_err, 1);
        chk("t3_ena", proj_ena, 20'h00080);
        chk("t3_cur", cur_addr, 7);
        cyc(1'b0, 1'b1, 1'b0, 0);
        chk("t3_err_clr", sel_if.sel_err, 0);

        // 4: move to 5, then drop ena
        cyc(1'b0, 1'b1, 1'b1, 5);
        for (int i = 0; i < GAP; i++) cyc(1'b0, 1'b1, 1'b0, 0);
        chk("t4_cur5", cur_addr, 5);
        for (int i = 0; i < GAP + 1; i++) cyc(1'b0, 1'b0, 1'b0, 0);
        chk("t4_idle", active, 0);
        chk("t4_ow0", ow, 0);
        // pending 9 cancelled by ena low mid-drain
        seen9 = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 5);
        cyc(1'b0, 1'b1, 1'b1, 9);
        cyc(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < GAP + 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 0);
            if (proj_ena[9]) seen9 = 1'b1;
        end
        chk("t4_never9", seen9, 0);
        chk("t4_idle2", active, 0);

        // 5: iw gating on slot 2, then reset mid-drain
        cyc(1'b0, 1'b1, 1'b1, 2);
        iw_fix = 1'b1; iw = 18'h2AAAA;
        cyc(1'b0, 1'b1, 1'b0, 0);
        ev = '0; ev[2*IW +: IW] = 18'h2AAAA;
        chk("t5_iw", proj_iw, ev);
        iw_fix = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 4);
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("t5_rst_ena", proj_ena, 0);
        chk("t5_rst_active", active, 0);
        chk("t5_rst_cur", cur_addr, 0);
        chk("t5_rst_ow", ow, 0);
        chk("t5_rst_ready", sel_if.sel_ready, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 31));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
